instr_issue_decoder: RTL and testbench
======================================

INSTR_ISSUE_DECODER -- requirements
Module: instr_issue_decoder

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports in_valid input 1, in_ready output 1, instr input 32  instruction-word valid/ready handshake.
REQ-004 SHALL have port flags  input  4  ALU flag register {N,Z,C,V}.
REQ-005 SHALL have port flags_upd  input  1  one-cycle pulse when the ALU writes the flags.
REQ-006 SHALL have ports out_valid output 1, out_ready input 1  ALU-issue handshake.
REQ-007 SHALL have outputs opcode 4, sr_cont 3, sr_bit 5, s_bit 1, immediate 16, rd 4, rn 4, rm 4  registered ALU control fields.
REQ-008 SHALL have outputs squash_o 1 and illegal_o 1  one-cycle event pulses.

Function
REQ-009 SHALL decode instr as: cond[31:28], opcode[27:24], s_bit[23], sr_cont[22:20], rd[19:16], rn[15:12], rm[11:8], sr_bit[7:3], immediate[15:0].
REQ-010 SHALL treat opcodes 0000-0111, 1000 (CMP), 1101 (LDR), 1110 (STR) as legal; all other opcodes are illegal.
REQ-011 SHALL evaluate cond: 0000 AL; 0001 EQ Z; 0010 NE !Z; 0011 CS C; 0100 CC !C; 0101 MI N; 0110 PL !N; 0111 VS V; 1000 VC !V; 1001 GT !Z&(N==V); 1010 GE N==V; 1011 LT N!=V; 1100 LE Z|(N!=V); 1101-1111 reserved, which is illegal.
REQ-012 SHALL implement FSM states EMPTY, WAIT, FULL; reset state is EMPTY.
REQ-013 SHALL keep a 2-bit pending counter of issued flag writers, where a flag writer is s_bit=1 or opcode 1000.
REQ-014 SHALL increment pending on an out handshake of a flag writer and decrement it on flags_upd; if both occur in one cycle, pending is unchanged; a decrement at 0 is ignored.
REQ-015 SHALL drive in_ready = (state==EMPTY | (state==FULL & out_ready)) & (pending!=3).
REQ-016 SHALL register an accepted instruction in the cycle after the handshake; from that cycle: if illegal, pulse illegal_o and go to EMPTY; else if cond!=AL and pending!=0, go to WAIT; else evaluate cond.
REQ-017 SHALL, when cond is true, go to FULL with out_valid=1; latency is 1 cycle from accept to out_valid.
REQ-018 SHALL, when cond is false, not issue the instruction, pulse squash_o for 1 cycle, go to EMPTY, and not count the instruction as a flag writer.
REQ-019 SHALL leave WAIT in the cycle after pending reaches 0, then evaluate cond against the current flags.
REQ-020 SHALL hold all output fields stable while out_valid=1 and out_ready=0.
REQ-021 SHALL sustain 1 instruction per cycle in FULL with out_ready=1 and in_valid=1 (back-to-back accept).
REQ-022 SHALL drive out_valid=0 in EMPTY and WAIT.

Reset
REQ-023 SHALL, on rst_n low, immediately force out_valid=0, all control fields=0, squash_o=0, illegal_o=0, pending=0, state=EMPTY.
REQ-024 SHALL drop any held or waiting instruction on reset mid-operation, with no pulse.
REQ-025 SHALL hold in_ready=0 while rst_n is low.

Configuration
REQ-026 SHALL, with macro ISSUE_PERF_CNT_EN defined, add outputs issue_cnt 16 and squash_cnt 16: reset to 0, increment on each issue handshake or squash_o pulse respectively, and wrap from 0xFFFF to 0.
REQ-027 SHALL, without ISSUE_PERF_CNT_EN, omit these ports and their logic; all other behaviour is identical.

Verification
REQ-028 SHALL cover: instr=0x00123456 accepted, out_ready=1 -> next cycle out_valid=1, opcode=0, rd=2, rn=3, rm=4, sr_bit=0x0A, sr_cont=1.
REQ-029 SHALL cover: CMP with S=1 issued, then EQ instr with flags_upd delayed 3 cycles -> state WAIT, out_valid=0 for 3 cycles; after the pulse, Z=1 issues and Z=0 gives a squash_o pulse.
REQ-030 SHALL cover: opcode 1010 or cond 1110 -> illegal_o pulses once, out_valid stays 0, pending unchanged.
REQ-031 SHALL cover: three S=1 issues with no flags_upd -> pending=3, in_ready=0; one flags_upd -> in_ready=1 next cycle; a simultaneous issue and flags_upd leaves pending unchanged.
REQ-032 SHALL cover: out_ready held 0 for 4 cycles in FULL -> fields stable, in_ready=0; rst_n asserted in WAIT -> out_valid=0 immediately, pending=0.

Source files
------------

// File: rtl/instr_issue_decoder.sv
// Instruction issue decoder: decodes, condition-checks and issues one instruction at a time
// to the ALU, holding conditional ones until in-flight flag writes land. Macro: ISSUE_PERF_CNT_EN.
module instr_issue_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [3:0]  flags,
    input  logic        flags_upd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  opcode,
    output logic [2:0]  sr_cont,
    output logic [4:0]  sr_bit,
    output logic        s_bit,
    output logic [15:0] immediate,
    output logic [3:0]  rd,
    output logic [3:0]  rn,
    output logic [3:0]  rm,
    output logic        squash_o,
    output logic        illegal_o
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [15:0] issue_cnt,
    output logic [15:0] squash_cnt
`endif
);

    // state   | meaning
    // S_EMPTY | nothing held, ready for a new instruction
    // S_WAIT  | conditional instruction held until pending flag writes drain
    // S_FULL  | instruction presented to the ALU (out_valid=1)
    typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_FULL} state_t;

    state_t      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  pending_q, pending_d;
    logic        squash_q, squash_d;
    logic        illegal_q, illegal_d;
    logic        accept, issue, issue_fw, is_writer;
    logic [3:0]  cond_q, cond_in;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0:    return 1'b1;
            4'h1:    return z;
            4'h2:    return ~z;
            4'h3:    return cf;
            4'h4:    return ~cf;
            4'h5:    return n;
            4'h6:    return ~n;
            4'h7:    return v;
            4'h8:    return ~v;
            4'h9:    return ~z & (n == v);
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return z | (n != v);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic op_legal(input logic [3:0] op);
        return (op <= 4'h8) || (op == 4'hD) || (op == 4'hE);
    endfunction

    assign cond_q    = word_q[31:28];
    assign cond_in   = instr[31:28];
    assign opcode    = word_q[27:24];
    assign s_bit     = word_q[23];
    assign sr_cont   = word_q[22:20];
    assign rd        = word_q[19:16];
    assign rn        = word_q[15:12];
    assign rm        = word_q[11:8];
    assign sr_bit    = word_q[7:3];
    assign immediate = word_q[15:0];
    assign squash_o  = squash_q;
    assign illegal_o = illegal_q;

    assign out_valid = (state_q == S_FULL);
    assign in_ready  = rst_n & ((state_q == S_EMPTY) | ((state_q == S_FULL) & out_ready))
                       & (pending_q != 2'd3);
    assign accept    = in_valid & in_ready;
    assign issue     = out_valid & out_ready;
    assign is_writer = word_q[23] | (word_q[27:24] == 4'h8);
    assign issue_fw  = issue & is_writer;

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        pending_d = pending_q;
        squash_d  = 1'b0;
        illegal_d = 1'b0;

        // Saturate rather than wrap if the ALU is allowed to run far ahead of flag writes.
        if (issue_fw && !flags_upd) begin
            if (pending_q != 2'd3) pending_d = pending_q + 2'd1;
        end else if (flags_upd && !issue_fw && pending_q != 2'd0) begin
            pending_d = pending_q - 2'd1;
        end

        case (state_q)
            S_FULL: if (issue) state_d = S_EMPTY;
            S_WAIT: begin
                if (pending_q == 2'd0) begin
                    if (cond_pass(cond_q, flags)) begin
                        state_d = S_FULL;
                    end else begin
                        squash_d = 1'b1;
                        state_d  = S_EMPTY;
                    end
                end
            end
            default: ;
        endcase

        // A flag writer leaving this cycle makes the current flags stale too.
        if (accept) begin
            word_d = instr;
            if (!op_legal(instr[27:24]) || cond_in > 4'hC) begin
                illegal_d = 1'b1;
                state_d   = S_EMPTY;
            end else if (cond_in != 4'h0 && (pending_q != 2'd0 || issue_fw)) begin
                state_d = S_WAIT;
            end else if (cond_pass(cond_in, flags)) begin
                state_d = S_FULL;
            end else begin
                squash_d = 1'b1;
                state_d  = S_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_EMPTY;
            word_q    <= '0;
            pending_q <= '0;
            squash_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            pending_q <= pending_d;
            squash_q  <= squash_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    logic [15:0] issue_cnt_q, squash_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            if (issue)    issue_cnt_q  <= issue_cnt_q + 16'd1;
            if (squash_d) squash_cnt_q <= squash_cnt_q + 16'd1;
        end
    end

    assign issue_cnt  = issue_cnt_q;
    assign squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_instr_issue_decoder.sv
// Self-checking bench for instr_issue_decoder: directed vectors, an event-level reference
// model checked every cycle, and literal expectations for the key scenarios.
module tb_instr_issue_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [3:0]  flags = '0;
    logic        flags_upd = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  opcode, rd, rn, rm;
    logic [2:0]  sr_cont;
    logic [4:0]  sr_bit;
    logic        s_bit, squash_o, illegal_o;
    logic [15:0] immediate;
`ifdef ISSUE_PERF_CNT_EN
    logic [15:0] issue_cnt, squash_cnt;
`endif

    int errors = 0;
    int checks = 0;

    instr_issue_decoder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .flags(flags), .flags_upd(flags_upd),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .sr_cont(sr_cont), .sr_bit(sr_bit), .s_bit(s_bit),
        .immediate(immediate), .rd(rd), .rn(rn), .rm(rm),
        .squash_o(squash_o), .illegal_o(illegal_o)
`ifdef ISSUE_PERF_CNT_EN
        , .issue_cnt(issue_cnt), .squash_cnt(squash_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_word = '0;
    bit          m_have = 0;   // an instruction is being held
    bit          m_iss  = 0;   // held instruction is being offered to the ALU
    int          m_pend = 0;
    bit          m_sq = 0, m_il = 0;
    int          m_issue_n = 0, m_sq_n = 0;

    function automatic bit legal_op(input logic [3:0] op);
        return (op <= 7) || (op == 8) || (op == 13) || (op == 14);
    endfunction

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cc, v;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        case (c)
            0: return 1;   1: return z;   2: return !z;   3: return cc;
            4: return !cc; 5: return n;   6: return !n;   7: return v;
            8: return !v;  9: return !z && n == v;  10: return n == v;
            11: return n != v;  12: return z || n != v;
            default: return 0;
        endcase
    endfunction

    function automatic bit writer(input logic [31:0] w);
        return w[23] || w[27:24] == 4'h8;
    endfunction

    function automatic bit m_ready();
        return rst_n && (!m_have || (m_iss && out_ready)) && m_pend < 3;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit acc, iss, fwi;
        int np;
        if (!rst_n) begin
            m_word = '0; m_have = 0; m_iss = 0; m_pend = 0; m_sq = 0; m_il = 0;
            m_issue_n = 0; m_sq_n = 0;
        end else begin
            acc = in_valid && m_ready();
            iss = m_have && m_iss && out_ready;
            fwi = iss && writer(m_word);
            m_sq = 0; m_il = 0;
            if (iss) begin
                m_have = 0;
                m_issue_n++;
            end
            if (m_have && !m_iss && m_pend == 0) begin
                if (cond_ok(m_word[31:28], flags)) m_iss = 1;
                else begin m_sq = 1; m_have = 0; end
            end
            np = m_pend;
            if (fwi && !flags_upd) np = (np < 3) ? np + 1 : 3;
            else if (flags_upd && !fwi && np > 0) np = np - 1;
            if (acc) begin
                m_word = instr;
                if (!legal_op(instr[27:24]) || instr[31:28] > 12) begin
                    m_il = 1; m_have = 0;
                end else if (instr[31:28] != 0 && (m_pend != 0 || fwi)) begin
                    m_have = 1; m_iss = 0;
                end else if (cond_ok(instr[31:28], flags)) begin
                    m_have = 1; m_iss = 1;
                end else begin
                    m_sq = 1; m_have = 0;
                end
            end
            m_pend = np;
            if (m_sq) m_sq_n++;
        end
    end

    always @(negedge clk) begin : compare
        if (!rst_n) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
        end else begin
            chk("in_ready", in_ready, m_ready());
            chk("out_valid", out_valid, m_have && m_iss);
            chk("squash_o", squash_o, m_sq);
            chk("illegal_o", illegal_o, m_il);
            if (m_have && m_iss) begin
                chk("opcode", opcode, m_word[27:24]);
                chk("s_bit", s_bit, m_word[23]);
                chk("sr_cont", sr_cont, m_word[22:20]);
                chk("rd", rd, m_word[19:16]);
                chk("rn", rn, m_word[15:12]);
                chk("rm", rm, m_word[11:8]);
                chk("sr_bit", sr_bit, m_word[7:3]);
                chk("immediate", immediate, m_word[15:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] op, input logic s,
                                       input logic [2:0] sc, input logic [3:0] d, input logic [3:0] n,
                                       input logic [3:0] m, input logic [4:0] sb);
        return {c, op, s, sc, d, n, m, sb, 3'b000};
    endfunction

    task automatic cyc(input logic v, input logic [31:0] w, input logic ordy,
                       input logic [3:0] f, input logic fu);
        in_valid = v; instr = w; out_ready = ordy; flags = f; flags_upd = fu;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] cmp, eq, w, f, g;
        logic [3:0]  fl [4];
        fl[0] = 4'b0000; fl[1] = 4'b0100; fl[2] = 4'b1001; fl[3] = 4'b1010;
        cmp = mk(4'h0, 4'h8, 1'b1, 3'd0, 4'd1, 4'd2, 4'd3, 5'd0);
        eq  = mk(4'h1, 4'h0, 1'b0, 3'd2, 4'd4, 4'd5, 4'd6, 5'd3);
        w   = mk(4'h0, 4'h1, 1'b1, 3'd0, 4'd7, 4'd8, 4'd9, 5'd1);
        f   = mk(4'h0, 4'h3, 1'b0, 3'd5, 4'd10, 4'd11, 4'd12, 5'd17);
        g   = mk(4'h0, 4'h2, 1'b0, 3'd0, 4'd1, 4'd1, 4'd1, 5'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_opcode", opcode, 0);
        chk("reset_immediate", immediate, 0);
        chk("reset_rd", rd, 0);
        rst_n = 1'b1;
        #1;
        chk("post_reset_in_ready", in_ready, 1);

        // Basic decode, one-cycle latency
        cyc(1, 32'h00123456, 1, 4'h0, 0);
        chk("dec_valid", out_valid, 1);
        chk("dec_opcode", opcode, 0);
        chk("dec_rd", rd, 2);
        chk("dec_rn", rn, 3);
        chk("dec_rm", rm, 4);
        chk("dec_sr_bit", sr_bit, 5'h0A);
        chk("dec_sr_cont", sr_cont, 1);
        chk("dec_imm", immediate, 16'h3456);
        cyc(0, 0, 1, 4'h0, 0);
        chk("dec_drained", out_valid, 0);

        // CMP then EQ held in WAIT; Z=1 issues
        cyc(1, cmp, 1, 4'h0, 0);
        chk("cmp_valid", out_valid, 1);
        chk("cmp_opcode", opcode, 8);
        cyc(1, eq, 1, 4'h0, 0);
        chk("wait_valid0", out_valid, 0);
        cyc(0, 0, 1, 4'h0, 0);
        chk("wait_valid1", out_valid, 0);
        cyc(0, 0, 1, 4'h0, 0);
        chk("wait_valid2", out_valid, 0);
        cyc(0, 0, 1, 4'b0100, 1);
        chk("wait_valid3", out_valid, 0);
        chk("wait_in_ready", in_ready, 0);
        cyc(0, 0, 1, 4'b0100, 0);
        chk("wait_issue", out_valid, 1);
        chk("wait_issue_rd", rd, 4);
        cyc(0, 0, 1, 4'b0100, 0);

        // Same, Z=0 squashes
        cyc(1, cmp, 1, 4'h0, 0);
        cyc(1, eq, 1, 4'h0, 0);
        cyc(0, 0, 1, 4'h0, 0);
        cyc(0, 0, 1, 4'h0, 0);
        cyc(0, 0, 1, 4'h0, 1);
        cyc(0, 0, 1, 4'h0, 0);
        chk("squash_pulse", squash_o, 1);
        chk("squash_no_valid", out_valid, 0);
        cyc(0, 0, 1, 4'h0, 0);
        chk("squash_one_cycle", squash_o, 0);

        // Illegal opcode and reserved cond, both with S=1
        cyc(1, mk(4'h0, 4'hA, 1'b1, 3'd0, 4'd1, 4'd1, 4'd1, 5'd0), 1, 4'h0, 0);
        chk("illegal_op", illegal_o, 1);
        chk("illegal_op_valid", out_valid, 0);
        cyc(0, 0, 1, 4'h0, 0);
        chk("illegal_op_once", illegal_o, 0);
        cyc(1, mk(4'hE, 4'h1, 1'b1, 3'd0, 4'd1, 4'd1, 4'd1, 5'd0), 1, 4'h0, 0);
        chk("illegal_cond", illegal_o, 1);
        chk("illegal_cond_valid", out_valid, 0);
        cyc(0, 0, 1, 4'h0, 0);
        chk("illegal_cond_once", illegal_o, 0);
        cyc(1, eq, 1, 4'b0100, 0);
        chk("illegal_pending_zero", out_valid, 1);
        cyc(0, 0, 1, 4'b0100, 0);

        // Fill pending to 3, drain one, simultaneous issue+update
        cyc(1, w, 1, 4'h0, 0);
        cyc(1, w, 1, 4'h0, 0);
        cyc(1, w, 1, 4'h0, 0);
        cyc(0, 0, 1, 4'h0, 0);
        chk("pend3_in_ready", in_ready, 0);
        cyc(0, 0, 1, 4'h0, 1);
        chk("pend2_in_ready", in_ready, 1);
        cyc(1, w, 1, 4'h0, 0);
        chk("pend2_issue", out_valid, 1);
        cyc(0, 0, 1, 4'h0, 1);
        chk("simul_unchanged", in_ready, 1);
        cyc(0, 0, 1, 4'h0, 1);
        cyc(0, 0, 1, 4'h0, 1);
        cyc(1, eq, 1, 4'b0100, 0);
        chk("drained_issue", out_valid, 1);
        cyc(0, 0, 1, 4'b0100, 0);

        // Back-pressure in FULL
        cyc(1, f, 0, 4'h0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, g, 0, 4'h0, 0);
            chk("stall_valid", out_valid, 1);
            chk("stall_opcode", opcode, 3);
            chk("stall_rd", rd, 10);
            chk("stall_sr_bit", sr_bit, 17);
            chk("stall_in_ready", in_ready, 0);
        end
        cyc(1, g, 1, 4'h0, 0);
        chk("b2b_opcode", opcode, 2);
        cyc(0, 0, 1, 4'h0, 0);

        // Condition table sweep
        for (int c = 1; c <= 12; c++) begin
            for (int k = 0; k < 4; k++) begin
                cyc(1, mk(4'(c), 4'h1, 1'b0, 3'd0, 4'(c), 4'(k), 4'd0, 5'd0), 1, fl[k], 0);
                cyc(0, 0, 1, fl[k], 0);
            end
        end
        cyc(1, mk(4'h9, 4'h1, 1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 5'd0), 1, 4'b1001, 0);
        chk("gt_true", out_valid, 1);
        cyc(0, 0, 1, 4'b1001, 0);
        cyc(1, mk(4'hB, 4'h1, 1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 5'd0), 1, 4'b1001, 0);
        chk("lt_false", squash_o, 1);
        cyc(0, 0, 1, 4'b1000, 0);
        cyc(1, mk(4'hC, 4'h1, 1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 5'd0), 1, 4'b1000, 0);
        chk("le_true", out_valid, 1);
        cyc(0, 0, 1, 4'b1000, 0);

`ifdef ISSUE_PERF_CNT_EN
        chk("issue_cnt", issue_cnt, 32'(m_issue_n));
        chk("squash_cnt", squash_cnt, 32'(m_sq_n));
`endif

        // Reset while in WAIT
        cyc(1, cmp, 1, 4'h0, 0);
        cyc(1, eq, 1, 4'h0, 0);
        chk("rwait_valid", out_valid, 0);
        chk("rwait_in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("rwait_async_valid", out_valid, 0);
        chk("rwait_async_in_ready", in_ready, 0);
        cyc(0, 0, 0, 4'b0100, 0);
        rst_n = 1'b1;
        cyc(0, 0, 1, 4'b0100, 0);
        chk("rwait_no_squash", squash_o, 0);
        cyc(1, eq, 1, 4'b0100, 0);
        chk("rwait_pending_zero", out_valid, 1);
        cyc(0, 0, 1, 4'b0100, 0);

        // Reset while in FULL
        cyc(1, f, 0, 4'h0, 0);
        chk("rfull_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rfull_async_valid", out_valid, 0);
        chk("rfull_async_opcode", opcode, 0);
        cyc(0, 0, 0, 4'h0, 0);
        rst_n = 1'b1;
        cyc(0, 0, 1, 4'h0, 0);
        chk("rfull_idle", out_valid, 0);
        chk("rfull_no_illegal", illegal_o, 0);
        cyc(0, 0, 1, 4'h0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
